// File: rtl/seq_control.sv
// -----------------------------------------------------------------------------
// seq_control -- multi-cycle MIPS-style control sequencer.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB (states
// skipped as the instruction class allows) and drives the datapath strobes
// and multiplexer selects for the current step.
//
// Ports
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous, active-low reset
//   Opcode[5:0]  in   opcode from the instruction register, looked at in DECODE
//   MemReady     in   memory access complete (meaningful only while MemReq=1)
//   MemReq       out  memory access request
//   MemWrite     out  store access (qualified by MemReq)
//   IorD         out  address select: 0 = PC, 1 = ALU result
//   IRWrite      out  instruction register load
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  branch-conditional PC load
//   PCSrc[1:0]   out  00 = PC+4, 01 = branch target, 10 = jump target
//   ExtZero      out  1 = zero-extend immediate, 0 = sign-extend
//   ALUSrcA      out  0 = PC, 1 = rs
//   ALUSrcB[1:0] out  00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm << 2
//   ALUOp[1:0]   out  00 add, 01 sub, 10 funct field, 11 logical immediate
//   RegWrite     out  register file write
//   RegDst       out  destination select (1 = rd)
//   MemToReg     out  writeback select (1 = memory data)
//   Illegal      out  one-cycle pulse on an unsupported opcode
//   State[2:0]   out  current state code, for debug
//
// The datapath controls are a function of the registered state, the captured
// opcode and the live handshake inputs, because the FETCH/MEM handshake and
// the DECODE jump/illegal decisions must act in the same cycle they are seen.
// -----------------------------------------------------------------------------
module seq_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSrc,
    output logic       ExtZero,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       Illegal,
    output logic [2:0] State
);

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // Instruction classes: every rule below depends only on the class.
    typedef enum logic [2:0] {
        CL_RTYPE   = 3'd0,
        CL_JUMP    = 3'd1,
        CL_BEQ     = 3'd2,
        CL_ADDI    = 3'd3,
        CL_LOGIC   = 3'd4,
        CL_LOAD    = 3'd5,
        CL_STORE   = 3'd6,
        CL_ILLEGAL = 3'd7
    } op_class_t;

    // Map a raw opcode onto its instruction class.
    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t cl;
        case (op)
            OP_RTYPE: cl = CL_RTYPE;
            OP_J:     cl = CL_JUMP;
            OP_BEQ:   cl = CL_BEQ;
            OP_ADDI:  cl = CL_ADDI;
            OP_ANDI:  cl = CL_LOGIC;
            OP_ORI:   cl = CL_LOGIC;
            OP_XORI:  cl = CL_LOGIC;
            OP_LW:    cl = CL_LOAD;
            OP_SW:    cl = CL_STORE;
            default:  cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic [5:0] opcode_q;
    logic [5:0] opcode_d;

    op_class_t  live_class_s;   // class of the opcode on the input pins
    op_class_t  cap_class_s;    // class of the opcode captured in DECODE

    logic       mem_req_s;
    logic       mem_write_s;
    logic       iord_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic [1:0] pc_src_s;
    logic       ext_zero_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic       reg_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       illegal_s;

    assign live_class_s = classify(Opcode);
    assign cap_class_s  = classify(opcode_q);

    // Next-state and opcode-capture logic.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_FETCH: begin
                if (MemReady) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Later states work from this copy, never from the live pins.
                opcode_d = Opcode;
                case (live_class_s)
                    CL_JUMP:    state_d = ST_FETCH;
                    CL_ILLEGAL: state_d = ST_FETCH;
                    default:    state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cap_class_s)
                    CL_RTYPE: state_d = ST_WB;
                    CL_ADDI:  state_d = ST_WB;
                    CL_LOGIC: state_d = ST_WB;
                    CL_LOAD:  state_d = ST_MEM;
                    CL_STORE: state_d = ST_MEM;
                    CL_BEQ:   state_d = ST_FETCH;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                // Wait here with the request held until memory answers.
                if (MemReady) begin
                    if (cap_class_s == CL_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            default: begin
                // Codes 5-7 cannot be reached; recover to FETCH.
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and captured-opcode registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_FETCH;
            opcode_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Datapath control decode for the current step.
    always_comb begin
        mem_req_s       = 1'b0;
        mem_write_s     = 1'b0;
        iord_s          = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        pc_src_s        = 2'b00;
        ext_zero_s      = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        reg_write_s     = 1'b0;
        reg_dst_s       = 1'b0;
        mem_to_reg_s    = 1'b0;
        illegal_s       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Instruction read at PC while the ALU forms PC+4.
                mem_req_s   = 1'b1;
                iord_s      = 1'b0;
                alu_src_a_s = 1'b0;
                alu_src_b_s = 2'b01;
                if (MemReady) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    pc_src_s   = 2'b00;
                end else begin
                    ir_write_s = 1'b0;
                end
            end
            ST_DECODE: begin
                // ALU speculatively computes the branch target.
                alu_src_a_s = 1'b0;
                alu_src_b_s = 2'b11;
                alu_op_s    = 2'b00;
                case (live_class_s)
                    CL_JUMP: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'b10;
                    end
                    CL_ILLEGAL: begin
                        illegal_s = 1'b1;
                    end
                    default: begin
                        illegal_s = 1'b0;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_src_a_s = 1'b1;
                case (cap_class_s)
                    CL_RTYPE: begin
                        alu_src_b_s = 2'b00;
                        alu_op_s    = 2'b10;
                    end
                    CL_ADDI: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b00;
                    end
                    CL_LOGIC: begin
                        // Logical immediates are zero-extended.
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b11;
                        ext_zero_s  = 1'b1;
                    end
                    CL_LOAD: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b00;
                    end
                    CL_STORE: begin
                        alu_src_b_s = 2'b10;
                        alu_op_s    = 2'b00;
                    end
                    CL_BEQ: begin
                        // Subtract rs-rt; the datapath gates the PC load on zero.
                        alu_src_b_s     = 2'b00;
                        alu_op_s        = 2'b01;
                        pc_write_cond_s = 1'b1;
                        pc_src_s        = 2'b01;
                    end
                    default: begin
                        alu_src_a_s = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                mem_write_s = (cap_class_s == CL_STORE);
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = (cap_class_s == CL_RTYPE);
                mem_to_reg_s = (cap_class_s == CL_LOAD);
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Output stage: while Reset is low only the FETCH request stays visible,
    // so no strobe or select can leak out during or at the instant of reset.
    always_comb begin
        MemReq = mem_req_s;
        State  = state_q;
        if (Reset) begin
            MemWrite    = mem_write_s;
            IorD        = iord_s;
            IRWrite     = ir_write_s;
            PCWrite     = pc_write_s;
            PCWriteCond = pc_write_cond_s;
            PCSrc       = pc_src_s;
            ExtZero     = ext_zero_s;
            ALUSrcA     = alu_src_a_s;
            ALUSrcB     = alu_src_b_s;
            ALUOp       = alu_op_s;
            RegWrite    = reg_write_s;
            RegDst      = reg_dst_s;
            MemToReg    = mem_to_reg_s;
            Illegal     = illegal_s;
        end else begin
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSrc       = 2'b00;
            ExtZero     = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            MemToReg    = 1'b0;
            Illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// -----------------------------------------------------------------------------
// tb_seq_control -- self-checking bench for seq_control.
//
// Each instruction is expanded into a script of per-cycle records (inputs to
// drive plus the full expected output set) built from the instruction's
// documented cycle sequence; the script is then played against the DUT with
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_control;

    logic       Clk;
    logic       Reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       MemReq, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSrc;
    logic       ExtZero, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       RegWrite, RegDst, MemToReg, Illegal;
    logic [2:0] State;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       ext_zero;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic [2:0] state;
    } outs_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    outs_t      obs;
    int         total;
    int         bad;

    logic       mr_q  [$];
    logic [5:0] op_q  [$];
    outs_t      exp_q [$];
    string      tag_q [$];

    logic [5:0] pool [9] = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI,
                             OP_ORI, OP_XORI, OP_LW, OP_SW};

    seq_control dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .MemReq      (MemReq),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .ExtZero     (ExtZero),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemToReg    (MemToReg),
        .Illegal     (Illegal),
        .State       (State)
    );

    assign obs = {MemReq, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
                  ExtZero, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, MemToReg,
                  Illegal, State};

    // 10 ns clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case the run ever wedges.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t base(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        for (int i = 0; i < 9; i++) begin
            if (pool[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input outs_t e, input string t);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h (t=%0t)", t, obs, e, $time);
        end
    endtask

    task automatic push(input logic mr, input logic [5:0] op, input outs_t e, input string t);
        mr_q.push_back(mr);
        op_q.push_back(op);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Expand one instruction into its cycle-by-cycle script.
    // wf/wm: cycles MemReady stays low in FETCH/MEM before completing.
    // Non-DECODE cycles drive 'other' on Opcode when use_other, else junk.
    task automatic gen_instr(input logic [5:0] op, input int wf, input int wm,
                             input bit use_other, input logic [5:0] other,
                             input string name);
        outs_t      e;
        logic [5:0] ot;
        for (int i = 0; i <= wf; i++) begin
            ot = use_other ? other : rnd6();
            e = base(3'd0);
            e.mem_req   = 1'b1;
            e.alu_src_b = 2'b01;
            if (i == wf) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
                push(1'b1, ot, e, {name, ".fetch"});
            end else begin
                push(1'b0, ot, e, {name, ".fetch_wait"});
            end
        end
        e = base(3'd1);
        e.alu_src_b = 2'b11;
        if (op == OP_J) begin
            e.pc_write = 1'b1;
            e.pc_src   = 2'b10;
        end else if (!is_legal(op)) begin
            e.illegal = 1'b1;
        end
        push(rnd1(), op, e, {name, ".decode"});
        if (op == OP_J || !is_legal(op)) return;

        ot = use_other ? other : rnd6();
        e = base(3'd2);
        e.alu_src_a = 1'b1;
        case (op)
            OP_R:    e.alu_op = 2'b10;
            OP_BEQ: begin
                e.alu_op        = 2'b01;
                e.pc_write_cond = 1'b1;
                e.pc_src        = 2'b01;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                e.alu_src_b = 2'b10;
                e.alu_op    = 2'b11;
                e.ext_zero  = 1'b1;
            end
            default: e.alu_src_b = 2'b10;   // addi, lw, sw
        endcase
        push(rnd1(), ot, e, {name, ".exec"});
        if (op == OP_BEQ) return;

        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i <= wm; i++) begin
                ot = use_other ? other : rnd6();
                e = base(3'd3);
                e.mem_req   = 1'b1;
                e.iord      = 1'b1;
                e.mem_write = (op == OP_SW);
                push((i == wm), ot, e, {name, ".mem"});
            end
            if (op == OP_SW) return;
        end

        ot = use_other ? other : rnd6();
        e = base(3'd4);
        e.reg_write  = 1'b1;
        e.reg_dst    = (op == OP_R);
        e.mem_to_reg = (op == OP_LW);
        push(rnd1(), ot, e, {name, ".wb"});
    endtask

    // Play up to n queued records (n < 0: all); leftovers are dropped.
    // Entered and left just after a rising edge.
    task automatic run(input int n);
        int k;
        k = 0;
        while (exp_q.size() > 0 && (n < 0 || k < n)) begin
            MemReady = mr_q.pop_front();
            Opcode   = op_q.pop_front();
            @(negedge Clk);
            check(exp_q.pop_front(), tag_q.pop_front());
            @(posedge Clk);
            #1;
            k++;
        end
        mr_q.delete();
        op_q.delete();
        exp_q.delete();
        tag_q.delete();
    endtask

    // Pulse reset asynchronously and check the held/released outputs.
    task automatic reset_pulse(input string t);
        outs_t rst_e;
        outs_t fetch_e;
        rst_e = base(3'd0);
        rst_e.mem_req = 1'b1;
        fetch_e = rst_e;
        fetch_e.alu_src_b = 2'b01;
        Reset    = 1'b0;
        MemReady = 1'b1;
        #1;
        check(rst_e, {t, ".rst_instant"});
        @(negedge Clk);
        check(rst_e, {t, ".rst_held"});
        @(posedge Clk);
        #1;
        check(rst_e, {t, ".rst_after_edge"});
        MemReady = 1'b0;
        Reset    = 1'b1;
        #1;
        check(fetch_e, {t, ".release_fetch"});
    endtask

    initial begin
        outs_t      e;
        logic [5:0] op;
        int         idx;
        total    = 0;
        bad      = 0;
        Reset    = 1'b0;
        MemReady = 1'b0;
        Opcode   = 6'd0;

        // Power-on reset, then release into FETCH.
        @(posedge Clk);
        #1;
        reset_pulse("por");

        // ori with MemReady tied high: states 0,1,2,4.
        gen_instr(OP_ORI, 0, 0, 1'b0, 6'd0, "ori");
        run(-1);

        // lw with three MemReady-low cycles in MEM (8 cycles total).
        gen_instr(OP_LW, 0, 3, 1'b0, 6'd0, "lw_wait");
        run(-1);

        // Unsupported opcode 111111.
        gen_instr(6'b111111, 0, 0, 1'b0, 6'd0, "illegal");
        run(-1);

        // addi, with Opcode switched to andi after DECODE.
        gen_instr(OP_ADDI, 1, 0, 1'b1, OP_ANDI, "addi_swap");
        run(-1);

        // beq then j back-to-back.
        gen_instr(OP_BEQ, 0, 0, 1'b0, 6'd0, "beq");
        gen_instr(OP_J, 0, 0, 1'b0, 6'd0, "j");
        run(-1);

        // sw with reset pulled mid-MEM: MemWrite must drop at once.
        gen_instr(OP_SW, 0, 3, 1'b0, 6'd0, "sw_rst");
        run(4);
        MemReady = 1'b0;
        #1;
        e = base(3'd3);
        e.mem_req   = 1'b1;
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
        check(e, "sw_rst.mem_before_reset");
        reset_pulse("sw_rst");
        gen_instr(OP_R, 0, 0, 1'b0, 6'd0, "r_after_rst");
        run(-1);

        // lw abandoned at WB: the writeback strobe must never appear.
        gen_instr(OP_LW, 0, 0, 1'b0, 6'd0, "lw_rst");
        run(4);
        reset_pulse("lw_rst");
        gen_instr(OP_XORI, 2, 0, 1'b0, 6'd0, "xori_after_rst");
        run(-1);

        // Randomised instruction stream with random handshake delays.
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 10);
            if (idx >= 9) begin
                do op = rnd6(); while (is_legal(op));
            end else begin
                op = pool[idx];
            end
            gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'b0, 6'd0, $sformatf("rnd%0d_op%b", n, op));
            run(-1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameters: none.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 Opcode  in  6  instruction opcode from instruction register; sampled in DECODE only.
REQ-005 MemReady  in  1  memory access complete; honoured only while MemReq=1.
REQ-006 MemReq  out  1  memory access request, held until MemReady.
REQ-007 MemWrite  out  1  store access; valid with MemReq.
REQ-008 IorD  out  1  address select: 0 = PC, 1 = ALU result.
REQ-009 IRWrite, PCWrite, PCWriteCond  out  1 each  instruction register load, unconditional PC load, branch-conditional PC load.
REQ-010 PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
REQ-011 ExtZero  out  1  extension-unit mode: 1 = zero-extend immediate, 0 = sign-extend.
REQ-012 ALUSrcA  out  1 (0 = PC, 1 = rs); ALUSrcB  out  2 (00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2); ALUOp  out  2 (00 add, 01 sub, 10 funct, 11 logical-imm).
REQ-013 RegWrite, RegDst, MemToReg  out  1 each  register write, dest select (1 = rd), writeback select (1 = memory data).
REQ-014 Illegal  out  1  one-cycle pulse on unsupported opcode.
REQ-015 State  out  3  current state encoding, for debug.

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 unreachable, SHALL go to FETCH on the next edge.
REQ-017 Supported opcodes: R-type 000000, j 000010, beq 000100, addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011.
REQ-018 Output defaults: all outputs 0 unless a state rule asserts them.
REQ-019 FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01. If MemReady=1: IRWrite=1, PCWrite=1, PCSrc=00, next state DECODE. Otherwise remain in FETCH.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Captures Opcode into an internal register; EXEC, MEM and WB use only the captured value.
REQ-021 DECODE with j: PCWrite=1, PCSrc=10, next state FETCH.
REQ-022 DECODE with unsupported opcode: Illegal=1 for this cycle only, next state FETCH, no other write strobe.
REQ-023 DECODE with any other supported opcode: next state EXEC.
REQ-024 EXEC, R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10, next state WB.
REQ-025 EXEC, addi: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtZero=0, next state WB.
REQ-026 EXEC, andi/ori/xori: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ExtZero=1, next state WB.
REQ-027 EXEC, lw/sw: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ExtZero=0, next state MEM.
REQ-028 EXEC, beq: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, next state FETCH.
REQ-029 MEM: MemReq=1, IorD=1, MemWrite=1 for sw only. Outputs are held unchanged until MemReady=1. Then sw goes to FETCH and lw goes to WB.
REQ-030 WB: RegWrite=1. RegDst=1 for R-type, 0 otherwise. MemToReg=1 for lw only. Next state FETCH.
REQ-031 ExtZero is 1 only in EXEC for andi/ori/xori; it is 0 in every other state.
REQ-032 MemReady=1 outside FETCH/MEM is ignored. MemReady=1 on the first cycle of FETCH/MEM completes the access in that cycle (minimum FETCH/MEM duration: 1 cycle).
REQ-033 Cycle counts with MemReady always 1: j 2, beq 3, R-type/I-arith 4, sw 4, lw 5.

Reset
REQ-034 Reset=0: State=FETCH and captured opcode=0 immediately, regardless of Clk.
REQ-035 While Reset=0: every output except MemReq is 0; State=0.
REQ-036 Reset asserted mid-MEM or mid-WB: the in-flight access or writeback is abandoned, with no strobe beyond the assertion instant.
REQ-037 After Reset returns to 1: the first rising edge evaluates FETCH rules, so MemReq=1 is visible from the deassertion.

Verification
REQ-038 ori (001101), MemReady tied 1 -> states 0,1,2,4,0; ExtZero=1 and ALUOp=11 only in the EXEC cycle; RegWrite=1 and RegDst=0 in WB.
REQ-039 lw with MemReady low 3 cycles in MEM -> MemReq=1, IorD=1, MemWrite=0 held 4 cycles; then WB with MemToReg=1 and RegWrite=1; total 8 cycles.
REQ-040 Opcode 111111 -> Illegal pulses for exactly 1 cycle in DECODE; next state FETCH; RegWrite, PCWrite and MemReq never asserted after IRWrite.
REQ-041 Opcode changed in EXEC from addi to andi -> ExtZero stays 0 and ALUOp stays 00 (captured opcode used).
REQ-042 Reset pulsed low mid-MEM of sw -> MemWrite drops asynchronously; State=0; after release the next fetch proceeds normally.
REQ-043 beq then j back-to-back -> PCWriteCond=1 with PCSrc=01 in beq's EXEC cycle; PCWrite=1 with PCSrc=10 in j's DECODE cycle.
